vram_write_scheduler: RTL

- Shares the background and object video-RAM write ports among several game-logic requesters (map updater, player, bomb and flame engines).
- Round-robin arbitration; granted writes are buffered in a small FIFO.
- FIFO drains only during vertical blanking, so the display fetch pipeline never sees a tile or object change mid-frame.
- Sits between the game logic and the dual-port background/object RAMs; display_driver uses the read side of those RAMs.

---
 rtl/vram_pkg.sv | 41 ++++
 rtl/write_fifo.sv | 63 ++++++
 rtl/vram_write_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM write scheduler types and timing constants
package vram_pkg;

    // Vertical timing of the 640x480 display, in lines
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;

    // Background tile grid: 20 columns by 15 rows of 32x32 tiles
    localparam int BKG_COLS  = 20;
    localparam int BKG_ROWS  = 15;
    localparam int BKG_CELLS = BKG_COLS * BKG_ROWS;

    // Write target selection
    typedef enum logic {
        SEL_BKG = 1'b0,
        SEL_OBJ = 1'b1
    } sel_e;

    // Object RAM word layout
    localparam int OBJ_ON_BIT  = 12;
    localparam int OBJ_TILE_HI = 11;
    localparam int OBJ_TILE_LO = 9;
    localparam int OBJ_X_HI    = 8;
    localparam int OBJ_X_LO    = 4;
    localparam int OBJ_Y_HI    = 3;
    localparam int OBJ_Y_LO    = 0;

    // Buffered write entry
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 13;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        sel_e              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/write_fifo.sv
// rtl/write_fifo.sv - synchronous FIFO holding granted VRAM writes
module write_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     iPush,
    input  logic [WIDTH-1:0]         iData,
    input  logic                     iPop,
    output logic [WIDTH-1:0]         oData,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign oFull  = (count == (AW+1)'(DEPTH));
    assign oEmpty = (count == '0);
    assign oCount = count;
    assign oData  = mem[rdPtr];

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    assign doPush = iPush && (!oFull || iPop);
    assign doPop  = iPop && !oEmpty;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= iData;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// rtl/vram_write_scheduler.sv - round-robin VRAM write arbiter with blank-gated drain
module vram_write_scheduler
    import vram_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int V_ACT_START = VGA_V_SYNC + VGA_V_BP,
    parameter int V_ACT_END   = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE - 1,
    parameter int BKG_LIMIT   = BKG_COLS * BKG_ROWS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                iVCnt,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ-1:0]        iSel,
    input  logic [9*NUM_REQ-1:0]      iAddr,
    input  logic [13*NUM_REQ-1:0]     iData,
    output logic [NUM_REQ-1:0]        oAck,
    output logic                      oWe_bkg,
    output logic [8:0]                oWAddr_bkg,
    output logic [2:0]                oWData_bkg,
    output logic                      oWe_obj,
    output logic [2:0]                oWAddr_obj,
    output logic [12:0]               oWData_obj,
    output logic                      oBlank,
    output logic                      oErr,
    output logic                      oFull
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                blankNow;
    logic                pop;
    logic                found;
    logic                grant;
    logic                rangeErr;
    logic                push;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    ptrNext;
    logic [NUM_REQ-1:0]  eligible;
    logic [ADDR_W-1:0]   addrArr [NUM_REQ];
    logic [DATA_W-1:0]   dataArr [NUM_REQ];
    wr_entry_t           pushEntry;
    wr_entry_t           popEntry;
    logic [ENTRY_W-1:0]  fifoRdata;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [CNT_W-1:0]    fifoCount;
    logic [CNT_W-1:0]    cntNext;

    assign blankNow = (iVCnt < 10'(V_ACT_START)) || (iVCnt > 10'(V_ACT_END));

    // Drain only on the registered blank flag so a pop never races the line counter
    assign pop = oBlank && !fifoEmpty;

    // A requester being acked this cycle has not yet had a chance to update its request
    assign eligible = iReq & ~oAck;

    // Split the flattened request buses into per-requester fields
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addrArr[k] = iAddr[k*ADDR_W +: ADDR_W];
            dataArr[k] = iData[k*DATA_W +: DATA_W];
        end
    end

    // Pick the first eligible requester at or after the round-robin pointer
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign ptrNext = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    assign pushEntry.sel  = sel_e'(iSel[winner]);
    assign pushEntry.addr = addrArr[winner];
    assign pushEntry.data = dataArr[winner];

    // Object writes only look at addr[2:0], so only background writes can be out of range
    assign rangeErr = (pushEntry.sel == SEL_BKG) && (pushEntry.addr >= ADDR_W'(BKG_LIMIT));
    assign grant    = found && (!fifoFull || pop);
    assign push     = grant && !rangeErr;
    assign cntNext  = fifoCount + CNT_W'(push) - CNT_W'(pop);

    write_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .iPush   (push),
        .iData   (pushEntry),
        .iPop    (pop),
        .oData   (fifoRdata),
        .oFull   (fifoFull),
        .oEmpty  (fifoEmpty),
        .oCount  (fifoCount)
    );

    assign popEntry = fifoRdata;

    // Grant bookkeeping: acknowledge the winner, flag dropped writes, advance the pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr  <= '0;
            oAck <= '0;
            oErr <= 1'b0;
        end else begin
            oAck <= grant ? (NUM_REQ'(1) << winner) : '0;
            oErr <= grant && rangeErr;
            if (grant) begin
                ptr <= ptrNext;
            end
        end
    end

    // Blank flag, full flag and RAM write port registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oBlank     <= 1'b0;
            oFull      <= 1'b0;
            oWe_bkg    <= 1'b0;
            oWAddr_bkg <= '0;
            oWData_bkg <= '0;
            oWe_obj    <= 1'b0;
            oWAddr_obj <= '0;
            oWData_obj <= '0;
        end else begin
            oBlank  <= blankNow;
            oFull   <= (cntNext == CNT_W'(FIFO_DEPTH));
            oWe_bkg <= pop && (popEntry.sel == SEL_BKG);
            oWe_obj <= pop && (popEntry.sel == SEL_OBJ);
            if (pop) begin
                oWAddr_bkg <= popEntry.addr;
                oWData_bkg <= popEntry.data[2:0];
                oWAddr_obj <= popEntry.addr[2:0];
                oWData_obj <= popEntry.data;
            end
        end
    end

endmodule
